// File: rtl/slurm16_mem_pkg.sv
// Shared widths and requester encoding for the SLURM16 four-bank memory arbiter.
package slurm16_mem_pkg;

  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned BANK_AW   = 14;
  localparam int unsigned BANK_IW   = 2;
  localparam int unsigned DW        = 16;

  // Enumerator order is also the fixed priority order, highest first.
  typedef enum logic [1:0] {
    REQ_SPRITE = 2'd0,
    REQ_BG0    = 2'd1,
    REQ_FL     = 2'd2,
    REQ_CPU    = 2'd3
  } req_e;

endpackage

// File: rtl/slurm16_bank_arbiter.sv
// Fixed-priority arbiter for one RAM bank: picks the lowest-indexed requester
// that addresses this bank and drives the bank port from it.
module slurm16_bank_arbiter
  import slurm16_mem_pkg::*;
(
  input  logic [BANK_IW-1:0]              bank_idx,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ-1:0][BANK_IW-1:0] req_bank,
  input  logic [NUM_REQ-1:0][BANK_AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DW-1:0]      req_din,
  input  logic [NUM_REQ-1:0][1:0]         req_mask,
  output logic [BANK_AW-1:0]              bank_addr,
  output logic [DW-1:0]                   bank_din,
  output logic [1:0]                      bank_mask,
  output logic                            bank_wr,
  output logic [NUM_REQ-1:0]              grant
);

  logic found;

  always_comb begin
    grant     = '0;
    bank_addr = '0;
    bank_din  = '0;
    bank_mask = '0;
    bank_wr   = 1'b0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (req_bank[i] == bank_idx)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        bank_addr = req_addr[i];
        // Reads leave data/mask/strobe at zero.
        if (req_wr[i]) begin
          bank_din  = req_din[i];
          bank_mask = req_mask[i];
          bank_wr   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/slurm16_memory_arbiter.sv
// Four-bank memory arbiter: per-bank fixed-priority grant, ready/data returned
// one cycle after the grant from the bank recorded at the grant edge.
module slurm16_memory_arbiter
  import slurm16_mem_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTb,
  input  logic [15:0] sprite_memory_address,
  output logic [15:0] sprite_memory_data,
  input  logic        sprite_rvalid,
  output logic        sprite_rready,
  input  logic [15:0] bg0_memory_address,
  output logic [15:0] bg0_memory_data,
  input  logic        bg0_rvalid,
  output logic        bg0_rready,
  input  logic [15:0] fl_memory_address,
  input  logic [15:0] fl_memory_data,
  input  logic        fl_wvalid,
  output logic        fl_wready,
  input  logic [14:0] cpu_memory_address,
  input  logic [15:0] cpu_memory_data_in,
  output logic [15:0] cpu_memory_data,
  input  logic        cpu_wr,
  output logic        cpu_memory_success,
  input  logic [1:0]  cpu_wr_mask,
  output logic [13:0] B1_ADDR,
  input  logic [15:0] B1_DOUT,
  output logic [15:0] B1_DIN,
  output logic [1:0]  B1_MASK,
  output logic        B1_WR,
  output logic [13:0] B2_ADDR,
  input  logic [15:0] B2_DOUT,
  output logic [15:0] B2_DIN,
  output logic [1:0]  B2_MASK,
  output logic        B2_WR,
  output logic [13:0] B3_ADDR,
  input  logic [15:0] B3_DOUT,
  output logic [15:0] B3_DIN,
  output logic [1:0]  B3_MASK,
  output logic        B3_WR,
  output logic [13:0] B4_ADDR,
  input  logic [15:0] B4_DOUT,
  output logic [15:0] B4_DIN,
  output logic [1:0]  B4_MASK,
  output logic        B4_WR
);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_wr;
  logic [NUM_REQ-1:0][BANK_IW-1:0]   req_bank;
  logic [NUM_REQ-1:0][BANK_AW-1:0]   req_addr;
  logic [NUM_REQ-1:0][DW-1:0]        req_din;
  logic [NUM_REQ-1:0][1:0]           req_mask;

  logic [NUM_BANKS-1:0][BANK_AW-1:0] bank_addr;
  logic [NUM_BANKS-1:0][DW-1:0]      bank_din;
  logic [NUM_BANKS-1:0][1:0]         bank_mask;
  logic [NUM_BANKS-1:0]              bank_wr;
  logic [NUM_BANKS-1:0][NUM_REQ-1:0] bank_grant;
  logic [NUM_BANKS-1:0][DW-1:0]      bank_dout;

  logic [NUM_REQ-1:0]                grant_any;
  logic [NUM_REQ-1:0]                granted_q;
  logic [NUM_REQ-1:0][BANK_IW-1:0]   bank_q;
  logic [NUM_REQ-1:0][DW-1:0]        rdata;

  // Packed vectors are indexed by req_e; the CPU has no valid and always requests.
  assign req_valid = {1'b1, fl_wvalid, bg0_rvalid, sprite_rvalid};
  assign req_wr    = {cpu_wr, 1'b1, 1'b0, 1'b0};
  assign req_bank  = {{1'b0, cpu_memory_address[14]}, fl_memory_address[15:14],
                      bg0_memory_address[15:14], sprite_memory_address[15:14]};
  assign req_addr  = {cpu_memory_address[13:0], fl_memory_address[13:0],
                      bg0_memory_address[13:0], sprite_memory_address[13:0]};
  assign req_din   = {cpu_memory_data_in, fl_memory_data, 16'h0000, 16'h0000};
  assign req_mask  = {cpu_wr_mask, 2'b11, 2'b00, 2'b00};

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    slurm16_bank_arbiter u_bank_arbiter (
      .bank_idx  (BANK_IW'(b)),
      .req_valid (req_valid),
      .req_wr    (req_wr),
      .req_bank  (req_bank),
      .req_addr  (req_addr),
      .req_din   (req_din),
      .req_mask  (req_mask),
      .bank_addr (bank_addr[b]),
      .bank_din  (bank_din[b]),
      .bank_mask (bank_mask[b]),
      .bank_wr   (bank_wr[b]),
      .grant     (bank_grant[b])
    );
  end

  always_comb begin
    grant_any = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      grant_any = grant_any | bank_grant[b];
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTb) begin
      granted_q <= '0;
      bank_q    <= '0;
    end else begin
      granted_q <= grant_any;
      bank_q    <= req_bank;
    end
  end

  assign bank_dout = {B4_DOUT, B3_DOUT, B2_DOUT, B1_DOUT};

  always_comb begin
    rdata = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (granted_q[r]) rdata[r] = bank_dout[bank_q[r]];
    end
  end

  assign sprite_rready      = granted_q[REQ_SPRITE];
  assign bg0_rready         = granted_q[REQ_BG0];
  assign fl_wready          = granted_q[REQ_FL];
  assign cpu_memory_success = granted_q[REQ_CPU];
  assign sprite_memory_data = rdata[REQ_SPRITE];
  assign bg0_memory_data    = rdata[REQ_BG0];
  assign cpu_memory_data    = rdata[REQ_CPU];

  // Write strobes are suppressed while reset is held; address/data still follow arbitration.
  assign B1_ADDR = bank_addr[0];
  assign B1_DIN  = bank_din[0];
  assign B1_MASK = bank_mask[0];
  assign B1_WR   = bank_wr[0] & ~RSTb;
  assign B2_ADDR = bank_addr[1];
  assign B2_DIN  = bank_din[1];
  assign B2_MASK = bank_mask[1];
  assign B2_WR   = bank_wr[1] & ~RSTb;
  assign B3_ADDR = bank_addr[2];
  assign B3_DIN  = bank_din[2];
  assign B3_MASK = bank_mask[2];
  assign B3_WR   = bank_wr[2] & ~RSTb;
  assign B4_ADDR = bank_addr[3];
  assign B4_DIN  = bank_din[3];
  assign B4_MASK = bank_mask[3];
  assign B4_WR   = bank_wr[3] & ~RSTb;

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// Directed-vector bench for slurm16_memory_arbiter with constant per-bank read data.
module tb_slurm16_memory_arbiter;

  logic        CLK;
  logic        RSTb;
  logic [15:0] sprite_memory_address, sprite_memory_data;
  logic        sprite_rvalid, sprite_rready;
  logic [15:0] bg0_memory_address, bg0_memory_data;
  logic        bg0_rvalid, bg0_rready;
  logic [15:0] fl_memory_address, fl_memory_data;
  logic        fl_wvalid, fl_wready;
  logic [14:0] cpu_memory_address;
  logic [15:0] cpu_memory_data_in, cpu_memory_data;
  logic        cpu_wr, cpu_memory_success;
  logic [1:0]  cpu_wr_mask;
  logic [13:0] B1_ADDR, B2_ADDR, B3_ADDR, B4_ADDR;
  logic [15:0] B1_DOUT, B2_DOUT, B3_DOUT, B4_DOUT;
  logic [15:0] B1_DIN, B2_DIN, B3_DIN, B4_DIN;
  logic [1:0]  B1_MASK, B2_MASK, B3_MASK, B4_MASK;
  logic        B1_WR, B2_WR, B3_WR, B4_WR;

  int total = 0;
  int bad   = 0;

  slurm16_memory_arbiter dut (
    .CLK                   (CLK),
    .RSTb                  (RSTb),
    .sprite_memory_address (sprite_memory_address),
    .sprite_memory_data    (sprite_memory_data),
    .sprite_rvalid         (sprite_rvalid),
    .sprite_rready         (sprite_rready),
    .bg0_memory_address    (bg0_memory_address),
    .bg0_memory_data       (bg0_memory_data),
    .bg0_rvalid            (bg0_rvalid),
    .bg0_rready            (bg0_rready),
    .fl_memory_address     (fl_memory_address),
    .fl_memory_data        (fl_memory_data),
    .fl_wvalid             (fl_wvalid),
    .fl_wready             (fl_wready),
    .cpu_memory_address    (cpu_memory_address),
    .cpu_memory_data_in    (cpu_memory_data_in),
    .cpu_memory_data       (cpu_memory_data),
    .cpu_wr                (cpu_wr),
    .cpu_memory_success    (cpu_memory_success),
    .cpu_wr_mask           (cpu_wr_mask),
    .B1_ADDR (B1_ADDR), .B1_DOUT (B1_DOUT), .B1_DIN (B1_DIN), .B1_MASK (B1_MASK), .B1_WR (B1_WR),
    .B2_ADDR (B2_ADDR), .B2_DOUT (B2_DOUT), .B2_DIN (B2_DIN), .B2_MASK (B2_MASK), .B2_WR (B2_WR),
    .B3_ADDR (B3_ADDR), .B3_DOUT (B3_DOUT), .B3_DIN (B3_DIN), .B3_MASK (B3_MASK), .B3_WR (B3_WR),
    .B4_ADDR (B4_ADDR), .B4_DOUT (B4_DOUT), .B4_DIN (B4_DIN), .B4_MASK (B4_MASK), .B4_WR (B4_WR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; registered outputs are sampled there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    B1_DOUT = 16'hDEAD;
    B2_DOUT = 16'hBEEF;
    B3_DOUT = 16'h1234;
    B4_DOUT = 16'hECAF;
    sprite_memory_address = 16'h0000; sprite_rvalid = 1'b0;
    bg0_memory_address    = 16'h0000; bg0_rvalid    = 1'b0;
    fl_memory_address     = 16'h8000; fl_memory_data = 16'h1111; fl_wvalid = 1'b1;
    cpu_memory_address    = 15'h0000; cpu_memory_data_in = 16'h2222;
    cpu_wr = 1'b1; cpu_wr_mask = 2'b11;

    // Reset with writes pending: strobes must stay low, all returns cleared.
    RSTb = 1'b1;
    tick();
    tick();
    check("rst_sprite_rready", 16'(sprite_rready), 16'h0);
    check("rst_fl_wready", 16'(fl_wready), 16'h0);
    check("rst_cpu_success", 16'(cpu_memory_success), 16'h0);
    check("rst_cpu_data", cpu_memory_data, 16'h0000);
    check("rst_sprite_data", sprite_memory_data, 16'h0000);
    check("rst_b1_wr", 16'(B1_WR), 16'h0);
    check("rst_b3_wr", 16'(B3_WR), 16'h0);
    check("rst_b3_addr_follows", 16'(B3_ADDR), 16'h0000);
    RSTb = 1'b0; fl_wvalid = 1'b0; cpu_wr = 1'b0;
    tick();

    // Single sprite read, streamed for two cycles.
    sprite_memory_address = 16'h4000; sprite_rvalid = 1'b1;
    #1;
    check("spr_b2_addr", 16'(B2_ADDR), 16'h0000);
    check("spr_b2_wr", 16'(B2_WR), 16'h0);
    check("spr_rready_early", 16'(sprite_rready), 16'h0);
    tick();
    check("spr_rready_1", 16'(sprite_rready), 16'h1);
    check("spr_data_1", sprite_memory_data, 16'hBEEF);
    tick();
    check("spr_rready_2", 16'(sprite_rready), 16'h1);
    check("spr_data_2", sprite_memory_data, 16'hBEEF);
    sprite_rvalid = 1'b0;
    tick();
    check("spr_rready_off", 16'(sprite_rready), 16'h0);
    check("spr_data_off", sprite_memory_data, 16'h0000);

    // All four masters on different banks at once.
    sprite_memory_address = 16'h4000; sprite_rvalid = 1'b1;
    bg0_memory_address = 16'hC000; bg0_rvalid = 1'b1;
    fl_memory_address = 16'h8000; fl_memory_data = 16'hFFFF; fl_wvalid = 1'b1;
    cpu_memory_address = 15'h0200; cpu_wr = 1'b0;
    #1;
    check("par_b2_addr", 16'(B2_ADDR), 16'h0000);
    check("par_b4_addr", 16'(B4_ADDR), 16'h0000);
    check("par_b3_addr", 16'(B3_ADDR), 16'h0000);
    check("par_b3_din", B3_DIN, 16'hFFFF);
    check("par_b3_mask", 16'(B3_MASK), 16'h3);
    check("par_b3_wr", 16'(B3_WR), 16'h1);
    check("par_b1_addr", 16'(B1_ADDR), 16'h0200);
    check("par_b1_wr", 16'(B1_WR), 16'h0);
    tick();
    check("par_spr_rready", 16'(sprite_rready), 16'h1);
    check("par_bg0_rready", 16'(bg0_rready), 16'h1);
    check("par_fl_wready", 16'(fl_wready), 16'h1);
    check("par_cpu_success", 16'(cpu_memory_success), 16'h1);
    check("par_spr_data", sprite_memory_data, 16'hBEEF);
    check("par_bg0_data", bg0_memory_data, 16'hECAF);
    check("par_cpu_data", cpu_memory_data, 16'hDEAD);
    sprite_rvalid = 1'b0; bg0_rvalid = 1'b0; fl_wvalid = 1'b0;

    // Sprite beats CPU on bank 0.
    sprite_memory_address = 16'h0010; sprite_rvalid = 1'b1;
    cpu_memory_address = 15'h0200;
    #1;
    check("cfl_b1_addr", 16'(B1_ADDR), 16'h0010);
    tick();
    check("cfl_spr_rready", 16'(sprite_rready), 16'h1);
    check("cfl_spr_data", sprite_memory_data, 16'hDEAD);
    check("cfl_cpu_success", 16'(cpu_memory_success), 16'h0);
    check("cfl_cpu_data", cpu_memory_data, 16'h0000);
    sprite_rvalid = 1'b0;

    // CPU high-byte write to bank 1.
    cpu_wr = 1'b1; cpu_memory_address = 15'h4200;
    cpu_memory_data_in = 16'hCCCC; cpu_wr_mask = 2'b10;
    #1;
    check("cbw_b2_addr", 16'(B2_ADDR), 16'h0200);
    check("cbw_b2_din", B2_DIN, 16'hCCCC);
    check("cbw_b2_mask", 16'(B2_MASK), 16'h2);
    check("cbw_b2_wr", 16'(B2_WR), 16'h1);
    check("cbw_b1_wr", 16'(B1_WR), 16'h0);
    tick();
    check("cbw_cpu_success", 16'(cpu_memory_success), 16'h1);
    check("cbw_cpu_data", cpu_memory_data, 16'hBEEF);
    cpu_wr = 1'b0; cpu_memory_address = 15'h0000;

    // bg0 over fl on bank 3, then fl once bg0 releases.
    bg0_memory_address = 16'hC000; bg0_rvalid = 1'b1;
    fl_memory_address = 16'hC001; fl_memory_data = 16'h5A5A; fl_wvalid = 1'b1;
    #1;
    check("pri_b4_addr_bg0", 16'(B4_ADDR), 16'h0000);
    check("pri_b4_wr_bg0", 16'(B4_WR), 16'h0);
    tick();
    check("pri_bg0_rready", 16'(bg0_rready), 16'h1);
    check("pri_bg0_data", bg0_memory_data, 16'hECAF);
    check("pri_fl_wready_lost", 16'(fl_wready), 16'h0);
    bg0_rvalid = 1'b0;
    #1;
    check("pri_b4_addr_fl", 16'(B4_ADDR), 16'h0001);
    check("pri_b4_wr_fl", 16'(B4_WR), 16'h1);
    check("pri_b4_din_fl", B4_DIN, 16'h5A5A);
    check("pri_b4_mask_fl", 16'(B4_MASK), 16'h3);
    tick();
    check("pri_fl_wready", 16'(fl_wready), 16'h1);
    check("pri_bg0_rready_off", 16'(bg0_rready), 16'h0);
    fl_wvalid = 1'b0;

    // Reset mid-access drops the pending ready.
    sprite_memory_address = 16'h4000; sprite_rvalid = 1'b1;
    RSTb = 1'b1;
    tick();
    check("rma_spr_rready", 16'(sprite_rready), 16'h0);
    check("rma_spr_data", sprite_memory_data, 16'h0000);
    RSTb = 1'b0;
    tick();
    check("rma_spr_retry", 16'(sprite_rready), 16'h1);
    sprite_rvalid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
